// File: rtl/adpll_freq_ctrl.sv
// rtl/adpll_freq_ctrl.sv - ADPLL frequency controller: binary-search acquisition, +/-1 tracking, lock detect
module adpll_freq_ctrl #(
  parameter int CODE_W     = 8,
  parameter int SETTLE     = 2,
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 4
) (
  input  logic              ref_clk,
  input  logic              reset_n,
  input  logic              up,
  input  logic              dn,
  input  logic [2:0]        m,
  output logic [CODE_W-1:0] dco_code,
  output logic              lock,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } dir_t;

  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam int RW = $clog2(LOCK_CNT + 1);
  localparam int UW = $clog2(UNLOCK_CNT + 1);

  // Mid-scale start code and quarter-scale first search step.
  localparam logic [CODE_W-1:0] CODE_INIT = {1'b1, {(CODE_W-1){1'b0}}};
  localparam logic [CODE_W-2:0] STEP_INIT = {1'b1, {(CODE_W-2){1'b0}}};

  state_t            state_q, state_d;
  dir_t              prev_q, prev_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-2:0] step_q, step_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [RW-1:0]     rev_q, rev_d;
  logic [UW-1:0]     same_q, same_d;
  logic              lock_q, lock_d;
  logic [2:0]        m_q;

  logic              decide;
  logic              move;
  dir_t              dir;
  logic [CODE_W-1:0] amt;
  logic [CODE_W:0]   sum_wide;
  logic [CODE_W-1:0] code_inc;
  logic [CODE_W-1:0] code_dec;
  logic [CODE_W-1:0] code_moved;
  logic [RW-1:0]     rev_inc;
  logic [UW-1:0]     same_inc;

  // A decision is taken only once the DCO has had SETTLE idle cycles; UP==DN is a no-move.
  assign decide = (settle_q == SW'(SETTLE));
  assign move   = decide && (up ^ dn);
  assign dir    = up ? DIR_UP : DIR_DN;

  // Search moves by the current step, tracking/locked moves by one LSB; both saturate.
  assign amt        = (state_q == SEARCH) ? {1'b0, step_q} : CODE_W'(1);
  assign sum_wide   = {1'b0, code_q} + {1'b0, amt};
  assign code_inc   = sum_wide[CODE_W] ? {CODE_W{1'b1}} : sum_wide[CODE_W-1:0];
  assign code_dec   = (code_q < amt) ? '0 : (code_q - amt);
  assign code_moved = (dir == DIR_UP) ? code_inc : code_dec;

  // Counters stop at their thresholds rather than wrapping.
  assign rev_inc  = (rev_q == RW'(LOCK_CNT)) ? rev_q : rev_q + RW'(1);
  assign same_inc = (same_q == UW'(UNLOCK_CNT)) ? same_q : same_q + UW'(1);

  // Next-state and datapath update; an M change overrides everything with the start values.
  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    code_d   = code_q;
    step_d   = step_q;
    rev_d    = rev_q;
    same_d   = same_q;
    lock_d   = lock_q;
    settle_d = decide ? '0 : settle_q + SW'(1);

    if (move) begin
      code_d = code_moved;
      prev_d = dir;
      case (state_q)
        SEARCH: begin
          if (step_q == (CODE_W-1)'(1)) begin
            state_d = TRACK;
            rev_d   = '0;
          end else begin
            step_d = step_q >> 1;
          end
        end
        TRACK: begin
          if ((prev_q != DIR_NONE) && (dir != prev_q)) begin
            rev_d = rev_inc;
            if (rev_inc == RW'(LOCK_CNT)) begin
              state_d = LOCKED;
              lock_d  = 1'b1;
              same_d  = '0;
            end
          end else begin
            rev_d = '0;
          end
        end
        LOCKED: begin
          if (dir == prev_q) begin
            same_d = same_inc;
            if (same_inc == UW'(UNLOCK_CNT)) begin
              state_d = TRACK;
              lock_d  = 1'b0;
              rev_d   = '0;
            end
          end else begin
            same_d = '0;
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    if (m != m_q) begin
      state_d  = SEARCH;
      prev_d   = DIR_NONE;
      code_d   = CODE_INIT;
      step_d   = STEP_INIT;
      rev_d    = '0;
      same_d   = '0;
      lock_d   = 1'b0;
      settle_d = '0;
    end
  end

  // State register with asynchronous reset to the acquisition start point.
  always_ff @(posedge ref_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= SEARCH;
      prev_q   <= DIR_NONE;
      code_q   <= CODE_INIT;
      step_q   <= STEP_INIT;
      settle_q <= '0;
      rev_q    <= '0;
      same_q   <= '0;
      lock_q   <= 1'b0;
      m_q      <= m;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      code_q   <= code_d;
      step_q   <= step_d;
      settle_q <= settle_d;
      rev_q    <= rev_d;
      same_q   <= same_d;
      lock_q   <= lock_d;
      m_q      <= m;
    end
  end

  assign dco_code = code_q;
  assign lock     = lock_q;
  assign state    = state_q;

endmodule

// File: tb/tb_adpll_freq_ctrl.sv
// tb/tb_adpll_freq_ctrl.sv - scoreboard bench for adpll_freq_ctrl
module tb_adpll_freq_ctrl;

  logic       ref_clk = 1'b0;
  logic       reset_n;
  logic       up;
  logic       dn;
  logic [2:0] m;
  logic [7:0] dco_code;
  logic       lock;
  logic [1:0] state;

  typedef struct {
    logic       u;
    logic       d;
    logic [7:0] code;
    logic [1:0] st;
    logic       lk;
  } row_t;

  row_t sb[$];
  int   checks = 0;
  int   errors = 0;

  adpll_freq_ctrl #(
    .CODE_W(8), .SETTLE(2), .LOCK_CNT(8), .UNLOCK_CNT(4)
  ) dut (
    .ref_clk (ref_clk),
    .reset_n (reset_n),
    .up      (up),
    .dn      (dn),
    .m       (m),
    .dco_code(dco_code),
    .lock    (lock),
    .state   (state)
  );

  always #5 ref_clk = ~ref_clk;

  function automatic row_t r(input logic u, input logic d, input logic [7:0] c,
                             input logic [1:0] s, input logic l);
    row_t rr;
    rr.u = u; rr.d = d; rr.code = c; rr.st = s; rr.lk = l;
    return rr;
  endfunction

  task automatic hold_reset(input logic [2:0] mv);
    reset_n = 1'b0;
    up = 1'b0;
    dn = 1'b0;
    m = mv;
    repeat (2) @(posedge ref_clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge ref_clk);
    reset_n = 1'b1;
  endtask

  // Drive one decision and wait until the decision edge has passed.
  task automatic step(input logic u, input logic d);
    up = u;
    dn = d;
    repeat (3) @(posedge ref_clk);
    #1;
  endtask

  task automatic test_reset();
    row_t e;
    hold_reset(3'd1);
    sb.push_back(r(0, 0, 8'd128, 2'd0, 1'b0));
    e = sb.pop_front();
    checks++;
    if (dco_code !== e.code || state !== e.st || lock !== e.lk) begin
      errors++;
      $display("FAIL reset_hold: code=%0d state=%0d lock=%0b expected code=%0d state=%0d lock=%0b",
               dco_code, state, lock, e.code, e.st, e.lk);
    end
    release_reset();
    for (int i = 0; i < 10; i++) begin
      sb.push_back(r(0, 0, 8'd128, 2'd0, 1'b0));
      step(1'b0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (dco_code !== e.code || state !== e.st || lock !== e.lk) begin
        errors++;
        $display("FAIL reset_idle[%0d]: code=%0d state=%0d lock=%0b expected code=%0d state=%0d lock=%0b",
                 i, dco_code, state, lock, e.code, e.st, e.lk);
      end
    end
  endtask

  task automatic test_search_up();
    row_t rows[$];
    row_t e;
    hold_reset(3'd1);
    release_reset();
    rows.push_back(r(1, 0, 8'd192, 2'd0, 1'b0));
    rows.push_back(r(1, 0, 8'd224, 2'd0, 1'b0));
    rows.push_back(r(1, 0, 8'd240, 2'd0, 1'b0));
    rows.push_back(r(1, 0, 8'd248, 2'd0, 1'b0));
    rows.push_back(r(1, 0, 8'd252, 2'd0, 1'b0));
    rows.push_back(r(1, 0, 8'd254, 2'd0, 1'b0));
    rows.push_back(r(1, 0, 8'd255, 2'd1, 1'b0));
    rows.push_back(r(1, 0, 8'd255, 2'd1, 1'b0));
    rows.push_back(r(1, 0, 8'd255, 2'd1, 1'b0));
    rows.push_back(r(1, 0, 8'd255, 2'd1, 1'b0));
    foreach (rows[i]) begin
      sb.push_back(rows[i]);
      step(rows[i].u, rows[i].d);
      e = sb.pop_front();
      checks++;
      if (dco_code !== e.code || state !== e.st || lock !== e.lk) begin
        errors++;
        $display("FAIL search_up[%0d]: code=%0d state=%0d lock=%0b expected code=%0d state=%0d lock=%0b",
                 i, dco_code, state, lock, e.code, e.st, e.lk);
      end
    end
  endtask

  task automatic test_saturate_low();
    row_t rows[$];
    row_t e;
    hold_reset(3'd0);
    release_reset();
    rows.push_back(r(0, 1, 8'd64, 2'd0, 1'b0));
    rows.push_back(r(0, 1, 8'd32, 2'd0, 1'b0));
    rows.push_back(r(0, 1, 8'd16, 2'd0, 1'b0));
    rows.push_back(r(0, 1, 8'd8,  2'd0, 1'b0));
    rows.push_back(r(0, 1, 8'd4,  2'd0, 1'b0));
    rows.push_back(r(0, 1, 8'd2,  2'd0, 1'b0));
    rows.push_back(r(0, 1, 8'd1,  2'd1, 1'b0));
    rows.push_back(r(0, 1, 8'd0,  2'd1, 1'b0));
    rows.push_back(r(0, 1, 8'd0,  2'd1, 1'b0));
    foreach (rows[i]) begin
      sb.push_back(rows[i]);
      step(rows[i].u, rows[i].d);
      e = sb.pop_front();
      checks++;
      if (dco_code !== e.code || state !== e.st || lock !== e.lk) begin
        errors++;
        $display("FAIL saturate_low[%0d]: code=%0d state=%0d lock=%0b expected code=%0d state=%0d lock=%0b",
                 i, dco_code, state, lock, e.code, e.st, e.lk);
      end
    end
  endtask

  // Search to 99 entering TRACK with an UP move, then alternate to lock at 100.
  task automatic test_lock_track();
    row_t rows[$];
    row_t e;
    hold_reset(3'd0);
    release_reset();
    rows.push_back(r(0, 1, 8'd64,  2'd0, 1'b0));
    rows.push_back(r(1, 0, 8'd96,  2'd0, 1'b0));
    rows.push_back(r(1, 0, 8'd112, 2'd0, 1'b0));
    rows.push_back(r(0, 1, 8'd104, 2'd0, 1'b0));
    rows.push_back(r(0, 1, 8'd100, 2'd0, 1'b0));
    rows.push_back(r(0, 1, 8'd98,  2'd0, 1'b0));
    rows.push_back(r(1, 0, 8'd99,  2'd1, 1'b0));
    rows.push_back(r(1, 0, 8'd100, 2'd1, 1'b0));
    for (int k = 0; k < 7; k++) begin
      if (k % 2 == 0) rows.push_back(r(0, 1, 8'd99,  2'd1, 1'b0));
      else            rows.push_back(r(1, 0, 8'd100, 2'd1, 1'b0));
    end
    rows.push_back(r(1, 0, 8'd100, 2'd2, 1'b1));
    foreach (rows[i]) begin
      sb.push_back(rows[i]);
      step(rows[i].u, rows[i].d);
      e = sb.pop_front();
      checks++;
      if (dco_code !== e.code || state !== e.st || lock !== e.lk) begin
        errors++;
        $display("FAIL lock_track[%0d]: code=%0d state=%0d lock=%0b expected code=%0d state=%0d lock=%0b",
                 i, dco_code, state, lock, e.code, e.st, e.lk);
      end
    end
  endtask

  // Continues from the locked state left by test_lock_track.
  task automatic test_unlock();
    row_t rows[$];
    row_t e;
    rows.push_back(r(1, 0, 8'd101, 2'd2, 1'b1));
    rows.push_back(r(1, 0, 8'd102, 2'd2, 1'b1));
    rows.push_back(r(1, 0, 8'd103, 2'd2, 1'b1));
    rows.push_back(r(1, 0, 8'd104, 2'd1, 1'b0));
    rows.push_back(r(1, 0, 8'd105, 2'd1, 1'b0));
    foreach (rows[i]) begin
      sb.push_back(rows[i]);
      step(rows[i].u, rows[i].d);
      e = sb.pop_front();
      checks++;
      if (dco_code !== e.code || state !== e.st || lock !== e.lk) begin
        errors++;
        $display("FAIL unlock[%0d]: code=%0d state=%0d lock=%0b expected code=%0d state=%0d lock=%0b",
                 i, dco_code, state, lock, e.code, e.st, e.lk);
      end
    end
  endtask

  task automatic test_m_restart();
    row_t e;
    hold_reset(3'd1);
    release_reset();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    sb.push_back(r(1, 0, 8'd224, 2'd0, 1'b0));
    e = sb.pop_front();
    checks++;
    if (dco_code !== e.code || state !== e.st || lock !== e.lk) begin
      errors++;
      $display("FAIL m_restart_pre: code=%0d state=%0d lock=%0b expected code=%0d state=%0d lock=%0b",
               dco_code, state, lock, e.code, e.st, e.lk);
    end
    m = 3'd2;
    sb.push_back(r(1, 0, 8'd128, 2'd0, 1'b0));
    @(posedge ref_clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (dco_code !== e.code || state !== e.st || lock !== e.lk) begin
      errors++;
      $display("FAIL m_restart_edge: code=%0d state=%0d lock=%0b expected code=%0d state=%0d lock=%0b",
               dco_code, state, lock, e.code, e.st, e.lk);
    end
    sb.push_back(r(1, 0, 8'd192, 2'd0, 1'b0));
    step(1'b1, 1'b0);
    e = sb.pop_front();
    checks++;
    if (dco_code !== e.code || state !== e.st || lock !== e.lk) begin
      errors++;
      $display("FAIL m_restart_resume: code=%0d state=%0d lock=%0b expected code=%0d state=%0d lock=%0b",
               dco_code, state, lock, e.code, e.st, e.lk);
    end
  endtask

  task automatic test_no_move();
    row_t rows[$];
    row_t e;
    hold_reset(3'd0);
    release_reset();
    rows.push_back(r(1, 0, 8'd192, 2'd0, 1'b0));
    rows.push_back(r(1, 1, 8'd192, 2'd0, 1'b0));
    rows.push_back(r(0, 0, 8'd192, 2'd0, 1'b0));
    rows.push_back(r(1, 0, 8'd224, 2'd0, 1'b0));
    foreach (rows[i]) begin
      sb.push_back(rows[i]);
      step(rows[i].u, rows[i].d);
      e = sb.pop_front();
      checks++;
      if (dco_code !== e.code || state !== e.st || lock !== e.lk) begin
        errors++;
        $display("FAIL no_move[%0d]: code=%0d state=%0d lock=%0b expected code=%0d state=%0d lock=%0b",
                 i, dco_code, state, lock, e.code, e.st, e.lk);
      end
    end
  endtask

  task automatic test_reset_midop();
    row_t e;
    hold_reset(3'd0);
    release_reset();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    sb.push_back(r(0, 0, 8'd128, 2'd0, 1'b0));
    #1;
    e = sb.pop_front();
    checks++;
    if (dco_code !== e.code || state !== e.st || lock !== e.lk) begin
      errors++;
      $display("FAIL reset_midop: code=%0d state=%0d lock=%0b expected code=%0d state=%0d lock=%0b",
               dco_code, state, lock, e.code, e.st, e.lk);
    end
    release_reset();
  endtask

  initial begin
    reset_n = 1'b0;
    up = 1'b0;
    dn = 1'b0;
    m = 3'd0;
    test_reset();
    test_search_up();
    test_saturate_low();
    test_lock_track();
    test_unlock();
    test_m_restart();
    test_no_move();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
